// File: rtl/feature_packer_pkg.sv
// feature_packer_pkg: shared frame geometry and packer state encoding.
// Used by feature_packer and by the downstream classifier for the frame width.
package feature_packer_pkg;

    localparam int NUM_FEAT = 8;
    localparam int FEAT_W   = 4;
    localparam int FRAME_W  = NUM_FEAT * FEAT_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_FULL
    } pack_state_t;

endpackage

// File: rtl/feature_quant.sv
// feature_quant: combinational raw-sample quantiser (shift, then truncate or clamp).
// Define FEATURE_PACKER_SAT_EN to clamp instead of truncating.
module feature_quant #(
    parameter int IN_W   = 10,
    parameter int SHIFT  = 4,
    parameter int FEAT_W = 4
) (
    input  logic [IN_W-1:0]   s_data,
    output logic [FEAT_W-1:0] q
);

`ifdef FEATURE_PACKER_SAT_EN
    localparam logic [IN_W-1:0] Q_MAX = IN_W'((1 << FEAT_W) - 1);

    logic [IN_W-1:0] shifted;

    always_comb begin
        shifted = s_data >> SHIFT;
        q       = (shifted > Q_MAX) ? '1 : FEAT_W'(shifted);
    end
`else
    always_comb begin
        q = FEAT_W'(s_data >> SHIFT);
    end
`endif

endmodule

// File: rtl/feature_packer.sv
// feature_packer: gathers quantised samples into NUM_FEAT-lane frames for the classifier.
// Saturating quantisation is selected with FEATURE_PACKER_SAT_EN (see feature_quant).
module feature_packer #(
    parameter int IN_W     = 10,
    parameter int SHIFT    = 4,
    parameter int NUM_FEAT = 8,
    parameter int FEAT_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [IN_W-1:0]            s_data,
    input  logic                       s_first,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [NUM_FEAT*FEAT_W-1:0] m_data,
    output logic [7:0]                 drop_cnt
);

    import feature_packer_pkg::*;

    localparam int                IDX_W    = $clog2(NUM_FEAT);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_FEAT - 1);

    pack_state_t                 state, state_next;
    logic [IDX_W-1:0]            idx, idx_next;
    logic [NUM_FEAT*FEAT_W-1:0]  asm_frame, asm_next;
    logic [FEAT_W-1:0]           q;
    logic                        s_fire;
    logic                        out_free;
    logic                        load_out;
    logic                        drop_hit;

    feature_quant #(
        .IN_W   (IN_W),
        .SHIFT  (SHIFT),
        .FEAT_W (FEAT_W)
    ) u_quant (
        .s_data (s_data),
        .q      (q)
    );

    assign s_ready  = (state != ST_FULL);
    assign s_fire   = s_valid && s_ready;
    // Output register can take a frame this edge if empty or being drained now.
    assign out_free = !m_valid || m_ready;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        asm_next   = asm_frame;
        load_out   = 1'b0;
        drop_hit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_fire && s_first) begin
                    asm_next             = '0;
                    asm_next[FEAT_W-1:0] = q;
                    idx_next             = IDX_W'(1);
                    state_next           = ST_FILL;
                end
            end
            ST_FILL: begin
                if (s_fire) begin
                    if (s_first) begin
                        drop_hit             = 1'b1;
                        asm_next             = '0;
                        asm_next[FEAT_W-1:0] = q;
                        idx_next             = IDX_W'(1);
                    end else begin
                        asm_next[int'(idx)*FEAT_W +: FEAT_W] = q;
                        if (idx == LAST_IDX) begin
                            idx_next = '0;
                            if (out_free) begin
                                load_out   = 1'b1;
                                state_next = ST_IDLE;
                            end else begin
                                state_next = ST_FULL;
                            end
                        end else begin
                            idx_next = idx + 1'b1;
                        end
                    end
                end
            end
            ST_FULL: begin
                if (out_free) begin
                    load_out   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            asm_frame <= '0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            asm_frame <= asm_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
            drop_cnt <= '0;
        end else begin
            if (load_out) begin
                m_data  <= asm_next;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (drop_hit && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_feature_packer.sv
// tb_feature_packer: directed and random checks of feature_packer against a queue-based model.
// Honours FEATURE_PACKER_SAT_EN in its quantisation model.
module tb_feature_packer;

    localparam int FW = feature_packer_pkg::FRAME_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [9:0]    s_data = '0;
    logic          s_first = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [FW-1:0] m_data;
    logic [7:0]    drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: lanes of the frame being gathered, completed frames not yet
    // in the output register, and the expected output register contents.
    logic [3:0]    cur[$];
    logic [FW-1:0] pend[$];
    bit            exp_valid = 1'b0;
    logic [FW-1:0] exp_data = '0;
    int            exp_drop = 0;

    feature_packer #(
        .IN_W     (10),
        .SHIFT    (4),
        .NUM_FEAT (8),
        .FEAT_W   (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_first  (s_first),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] quant(input logic [9:0] d);
        int unsigned v;
        v = int'(d) / 16;
`ifdef FEATURE_PACKER_SAT_EN
        if (v > 15) v = 15;
`endif
        return 4'(v % 16);
    endfunction

    function automatic logic [FW-1:0] pack_cur();
        logic [FW-1:0] f;
        f = '0;
        foreach (cur[k]) f[k*4 +: 4] = cur[k];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_outputs();
        chk("m_valid", 32'(m_valid), 32'(exp_valid));
        chk("m_data", m_data, exp_data);
        chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        chk("s_ready", 32'(s_ready), 32'(pend.size() == 0));
    endtask

    task automatic step(input bit v, input logic [9:0] d, input bit f, input bit mr);
        bit accept;
        bit hs;
        s_valid = v;
        s_data  = d;
        s_first = f;
        m_ready = mr;
        accept  = v && (pend.size() == 0);
        hs      = exp_valid && mr;
        @(posedge clk);
        if (accept) begin
            if (f) begin
                if (cur.size() > 0 && exp_drop < 255) exp_drop++;
                cur.delete();
                cur.push_back(quant(d));
            end else if (cur.size() > 0) begin
                cur.push_back(quant(d));
                if (cur.size() == 8) begin
                    pend.push_back(pack_cur());
                    cur.delete();
                end
            end
        end
        if (hs) exp_valid = 1'b0;
        if (!exp_valid && pend.size() > 0) begin
            exp_data  = pend.pop_front();
            exp_valid = 1'b1;
        end
        #1;
        check_outputs();
    endtask

    task automatic hard_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_first = 1'b0;
        m_ready = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        cur.delete();
        pend.delete();
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_drop  = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
    endtask

    task automatic send_frame(input logic [9:0] base, input int dir, input bit mr);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 10'(int'(base) + dir * 16 * i), i == 0, mr);
        end
    endtask

    initial begin
        #3;
        hard_reset();

        // Ascending frame 0x010..0x080 with the classifier ready.
        send_frame(10'h010, 1, 1'b1);
        chk("frame_asc", m_data, 32'h8765_4321);
        chk("frame_asc_valid", 32'(m_valid), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Quantiser boundaries: 0x3F0 and 0x200.
        step(1'b1, 10'h3F0, 1'b1, 1'b1);
        step(1'b1, 10'h200, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 10'h010, 1'b0, 1'b1);
        chk("quant_3f0", 32'(m_data[3:0]), 32'hF);
`ifdef FEATURE_PACKER_SAT_EN
        chk("quant_200", 32'(m_data[7:4]), 32'hF);
`else
        chk("quant_200", 32'(m_data[7:4]), 32'h0);
`endif
        step(1'b0, '0, 1'b0, 1'b1);

        // Backpressure: A held in output, B waits in the assembly register.
        send_frame(10'h010, 1, 1'b0);
        send_frame(10'h0F0, -1, 1'b0);
        chk("full_s_ready", 32'(s_ready), 32'd0);
        step(1'b1, 10'h050, 1'b1, 1'b0);
        chk("full_hold_a", m_data, 32'h8765_4321);
        chk("full_s_ready2", 32'(s_ready), 32'd0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("full_b_out", m_data, 32'h89AB_CDEF);
        chk("full_b_valid", 32'(m_valid), 32'd1);
        chk("full_released", 32'(s_ready), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Mid-frame restart after 5 samples, then saturation of drop_cnt.
        for (int i = 0; i < 5; i++) step(1'b1, 10'h3FF, i == 0, 1'b1);
        send_frame(10'h0F0, -1, 1'b1);
        chk("drop_one", 32'(drop_cnt), 32'd1);
        chk("drop_new_frame", m_data, 32'h89AB_CDEF);
        for (int i = 0; i < 300; i++) step(1'b1, 10'(i), 1'b1, 1'b1);
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        // Reset mid-fill, then unframed samples must produce nothing.
        for (int i = 0; i < 4; i++) step(1'b1, 10'h020, i == 0, 1'b1);
        hard_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 10'h030, 1'b0, 1'b1);
        chk("no_orphan_frame", 32'(m_valid), 32'd0);

        // Random traffic with a reset dropped in halfway.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) hard_reset();
            step($urandom_range(0, 3) != 0, 10'($urandom_range(0, 1023)),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/feature_packer.md
FEATURE_PACKER -- requirements
Module: feature_packer

Interface
REQ-001 Parameter IN_W, default 10: width of each unsigned raw feature sample.
REQ-002 Parameter SHIFT, default 4: right-shift applied to each raw sample during quantisation.
REQ-003 Parameter NUM_FEAT, default 8: number of features per frame.
REQ-004 Parameter FEAT_W, default 4: width of each quantised feature.
REQ-005 The block SHALL use one clock and an asynchronous active-low reset.
REQ-006 Port clk, input, 1: rising-edge clock.
REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
REQ-008 Port s_valid, input, 1: raw sample valid.
REQ-009 Port s_ready, output, 1: block can accept a sample.
REQ-010 Port s_data, input, IN_W: raw unsigned sample.
REQ-011 Port s_first, input, 1: sample is feature 0 of a new frame.
REQ-012 Port m_valid, output, 1: packed frame valid toward the classifier.
REQ-013 Port m_ready, input, 1: classifier accepts the frame.
REQ-014 Port m_data, output, NUM_FEAT*FEAT_W (32): packed frame; feature k occupies bits [4k+3:4k].
REQ-015 Port drop_cnt, output, 8: saturating count of frames discarded because they were incomplete.

Function
REQ-016 A sample SHALL transfer only on a clock edge where s_valid and s_ready are both 1; an output frame SHALL transfer only where m_valid and m_ready are both 1.
REQ-017 Quantisation: q = s_data >> SHIFT; only the low FEAT_W bits are kept, unless the saturation option below is enabled.
REQ-018 The assembly register SHALL hold up to NUM_FEAT features, indexed by a 3-bit counter idx.
- Each accepted sample writes lane idx, then idx increments.
- An accepted sample with s_first=1 writes lane 0 and sets idx to 1.
REQ-019 If s_first=1 is accepted while idx is between 1 and NUM_FEAT-1, the partial frame SHALL be discarded, drop_cnt SHALL increment (saturating at 255), and the new sample SHALL start a fresh frame.
REQ-020 Before the first s_first after reset, samples with s_first=0 SHALL be ignored: they are accepted, not written, and not counted.
REQ-021 When lane NUM_FEAT-1 is written, the frame SHALL be complete.
- If the output register is empty, or m_ready=1 in the same cycle, the frame moves to the output register and m_valid=1 on the next cycle (1-cycle latency).
- Otherwise the frame stays in the assembly register in the FULL state.
REQ-022 States: IDLE (no frame started), FILL (idx 1..7), FULL (complete frame waiting for the output register).
- IDLE to FILL: on an accepted s_first.
- FILL to FILL/IDLE: FILL returns to IDLE after handover. A FILL that completes goes to FULL only when the output register is busy.
- FULL to IDLE: on the cycle the output register frees.
REQ-023 s_ready SHALL be 0 only in FULL; it SHALL NOT depend combinationally on s_valid.
REQ-024 m_data and m_valid SHALL be registered outputs.
- m_data SHALL remain stable while m_valid=1 and m_ready=0.
- Back-to-back frames SHALL sustain 1 frame per NUM_FEAT cycles when m_ready=1.
REQ-025 A simultaneous output handshake and a frame completion SHALL load the new frame with no bubble.

Reset
REQ-026 Asserting rst_n=0 SHALL, asynchronously, set state=IDLE, idx=0, m_valid=0, m_data=0, drop_cnt=0, and s_ready=1 once released.
REQ-027 A reset during FILL or FULL SHALL discard all frames; no partial frame is emitted after release.

Configuration
REQ-028 Macro FEATURE_PACKER_SAT_EN:
- When defined, q SHALL clamp to 2^FEAT_W-1 (15) whenever s_data>>SHIFT exceeds it.
- When undefined, q SHALL be the truncated low FEAT_W bits.

Structure
REQ-029 A shared package SHALL hold NUM_FEAT, FEAT_W, the packed-frame width (32), and the state enum. The classifier frame width SHALL be taken from the same package.
REQ-030 Quantisation SHALL be one sub-module, feature_quant (combinational, holds the saturation option); sequencing stays in feature_packer.

Verification
REQ-031 Reset, then 8 samples 0x010,0x020,...,0x080 with s_first on the first and m_ready=1 -> m_valid one cycle after the 8th, m_data=0x87654321.
REQ-032 Sample 0x3F0 with SAT_EN defined -> lane value 0xF; without it -> 0xF (0x3F & 0xF); sample 0x200 -> 0xF with it, 0x0 without it.
REQ-033 Hold m_ready=0 after frame A, then send a full frame B -> state FULL, s_ready=0, m_data=A stable; raise m_ready -> A taken, B appears next cycle, s_ready=1.
REQ-034 s_first mid-frame after 5 samples -> drop_cnt=1, the next output contains only the new frame's lanes; 300 such drops -> drop_cnt=255.
REQ-035 Assert rst_n low mid-FILL (idx=4) -> m_valid=0, drop_cnt=0 immediately; samples with s_first=0 after release produce no output.
